// File: rtl/booth_radix8_seq_multiplier.sv
// Iterative signed WIDTHxWIDTH radix-8 Booth multiplier, one digit/cycle.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_a/in_b request;
//   out_valid/out_ready/out_p (2*WIDTH) result; busy in CALC or DONE.
// Build macro BOOTH_EARLY_TERM_EN: stop CALC once remaining digits are zero.
module booth_radix8_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int NDIG = (WIDTH + 3) / 3;
  localparam int PW   = 2 * WIDTH;
  localparam int BW   = 3 * NDIG + 1;
  localparam int KW   = $clog2(NDIG + 1);
  localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   a3_q, a3_d;
  logic [BW-1:0]   b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   a_ext;
  logic [BW-1:0]   b_ext;
  logic [BW-1:0]   b_sh;
  logic [3:0]      grp;
  logic [PW-1:0]   mag;
  logic [PW-1:0]   mult;
  logic            neg;

  assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  // b[-1] = 0 sits at bit 0, so digit k is always b_q[3:0]
  // once b_q has been shifted right 3 bits per digit.
  assign b_ext = {{(BW-WIDTH-1){in_b[WIDTH-1]}}, in_b, 1'b0};
  assign b_sh  = $signed(b_q) >>> 3;
  assign grp   = b_q[3:0];

  // a_q / a3_q are pre-shifted by 3k, so no barrel shifter.
  always_comb begin
    neg = grp[3];
    mag = '0;
    case (grp)
      4'b0000, 4'b1111: mag = '0;
      4'b0001, 4'b0010,
      4'b1101, 4'b1110: mag = a_q;
      4'b0011, 4'b0100,
      4'b1011, 4'b1100: mag = a_q << 1;
      4'b0101, 4'b0110,
      4'b1001, 4'b1010: mag = a3_q;
      4'b0111, 4'b1000: mag = a_q << 2;
      default:          mag = '0;
    endcase
    mult = neg ? (~mag + PW'(1)) : mag;
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic rest_zero;
  // Remaining multiplier bits all equal the sign: every
  // later group is 0000 or 1111, i.e. digit 0.
  assign rest_zero = (b_sh == '0) || (&b_sh);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    a3_d    = a3_q;
    b_d     = b_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_ext;
          a3_d    = a_ext + (a_ext << 1);
          b_d     = b_ext;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + mult;
        a_d   = a_q << 3;
        a3_d  = a3_q << 3;
        b_d   = b_sh;
        k_d   = k_q + KW'(1);
        if (k_q == KLAST) begin
          state_d = S_DONE;
        end
`ifdef BOOTH_EARLY_TERM_EN
        else if (rest_zero) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      a_q         <= '0;
      a3_q        <= '0;
      b_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      a3_q        <= a3_d;
      b_q         <= b_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_p     = acc_q;

endmodule

// File: doc/booth_radix8_seq_multiplier.md
Name: booth_radix8_seq_multiplier

Overview:
Iterative signed WIDTHxWIDTH multiplier. It is the consumer side of the radix-8 Booth partial-product scheme. Per cycle it scans the multiplier into one overlapping 4-bit Booth group, recodes the group to a digit in -4..+4, selects the matching multiple of the multiplicand and accumulates it, shifted, into a 2*WIDTH product. It sits behind a valid/ready request port and drives a valid/ready result port to the datapath.

Parameters:
WIDTH, 32, operand width in bits; signed two's complement; must be >= 4.
NDIG, (WIDTH+3)/3 (integer division), number of Booth digits; derived, not overridable; 11 for WIDTH=32.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands (high only in IDLE)
in_a  in  WIDTH  multiplicand, signed
in_b  in  WIDTH  multiplier, signed
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_p  out  2*WIDTH  signed product a*b
busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; out_p=0.
  - Internal regs (acc, multiplicand regs, 3A reg, digit index) are cleared.
- Reset mid-operation: the operation is abandoned and no out_valid is produced.
- States:
  - IDLE: in_ready=1. in_valid&&in_ready at edge E0: latch sext(A) to 2*WIDTH, precompute 3A = A + 2A into a register, latch B sign-extended to 3*NDIG bits with an implicit b[-1]=0, acc=0, k=0, go to CALC.
  - CALC: one digit per cycle. Group g = {b[3k+2], b[3k+1], b[3k], b[3k-1]}. Digit d = -4*g3 + 2*g2 + g1 + g0.
    - Multiple M: 0, A, 2A, 3A or 4A, negated for negative d (two's complement, 2*WIDTH).
    - acc <= acc + (M << 3k), mod 2^(2*WIDTH). k <= k+1.
    - After digit NDIG-1, go to DONE.
  - DONE: out_valid=1 and out_p=acc, both held stable until out_ready. out_valid&&out_ready moves to IDLE.
    - in_ready stays 0 in DONE: no same-cycle accept. The next operand pair is accepted at the earliest one cycle later.
- Latency: out_valid is first high in the cycle after edge E0+NDIG (NDIG CALC cycles; 11 for WIDTH=32). Throughput is one result per NDIG+2 cycles with out_ready tied high.
- in_a/in_b are sampled only at acceptance and may change afterwards.
- in_valid during CALC/DONE is ignored and not dropped; the upstream holds it per valid/ready rules.
- out_p equals the exact signed product for all inputs, including min*min. For WIDTH=32: 0x80000000*0x80000000 = 0x4000000000000000.

Optional Feature:
BOOTH_EARLY_TERM_EN
- Defined: at the end of a CALC cycle processing digit k, if k<NDIG-1 and b[WIDTH-1 : 3k+2] are all equal to b[WIDTH-1], every remaining digit is zero. The block goes directly to DONE, so CALC takes k+1 cycles. The product is unchanged.
- Undefined: CALC always takes exactly NDIG cycles. Latency is fixed.

Test Plan:
- Reset, then a=3, b=5, out_ready=1 -> out_p=15, out_valid high 11 cycles after accept. With BOOTH_EARLY_TERM_EN: 2 cycles (digits -3, +1).
- a=-1 (0xFFFFFFFF), b=-1 -> out_p=0x0000000000000001. a=0x7FFFFFFF, b=0x80000000 -> out_p=0xC000000080000000.
- a=0x80000000, b=0x80000000 -> out_p=0x4000000000000000. a=0, b=0x12345678 -> out_p=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid/out_p stable and in_ready=0 throughout. out_ready=1 -> next cycle IDLE, in_ready=1.
- Reset mid-operation: rst_n low at CALC cycle 4 -> immediately out_valid=0, in_ready=1. After release, a=7, b=-9 -> out_p=0xFFFFFFFFFFFFFFC1 (-63), no stale result emitted.
- Random regression: 10k signed pairs including 0, ±1, min, max -> out_p == a*b. Early-term builds: cycle count <= 11.
